// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
//   ctrl_state_t : main control FSM states
//   OP_*         : instr[31:26] opcodes decoded by the controller
//   ALUOP_*      : 3-bit alu_op codes consumed by alu_control
//   SRCB_*       : alu_src_b mux encodings
//   PCSRC_*      : pc_source mux encodings
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } ctrl_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle main control FSM for the MIPS32 core.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB, drives datapath mux selects and
// write enables, stalls on mem_ready and aborts memory waits that last
// TIMEOUT_CYCLES cycles (mem_timeout pulse, back to FETCH, nothing written).
//
// Optional feature: define MIPS_MC_ADDI_EN to execute ADDI (opcode 001000)
// through ADDI_EX/ADDI_WB; otherwise ADDI decodes as illegal.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (outputs forced 0)
//   opcode[5:0]     instr[31:26], used in DECODE
//   mem_ready       memory completes current access this cycle
//   pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
//   alu_op[2:0], pc_source[1:0]    datapath controls
//   instr_done      pulse on last cycle of an instruction
//   illegal_op      pulse in DECODE for unsupported opcode
//   mem_timeout     pulse when a memory wait is abandoned
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT_CYCLES - 1);

    ctrl_state_t   state, state_nx;
    logic [CW-1:0] wait_cnt;
    logic          wait_st, at_lim;

    // Ungated decode; the reset mask is applied at the port boundary.
    logic       pc_write_d, pc_write_cond_d, iord_d, mem_read_d, mem_write_d;
    logic       ir_write_d, mem_to_reg_d, reg_dst_d, reg_write_d, alu_src_a_d;
    logic [1:0] alu_src_b_d, pc_source_d;
    logic [2:0] alu_op_d;
    logic       instr_done_d, illegal_op_d, mem_timeout_d;

    assign wait_st = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
    assign at_lim  = (wait_cnt == CNT_LIM);

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nx;
    end

    // Cleared whenever a wait state is left or re-entered (completion or
    // abort); otherwise counts stall cycles. Abort happens at CNT_LIM, so
    // the counter never passes it.
    always_ff @(posedge clk) begin
        if (rst)                                wait_cnt <= '0;
        else if (!wait_st || mem_ready || at_lim) wait_cnt <= '0;
        else                                    wait_cnt <= wait_cnt + 1'b1;
    end

    always_comb begin
        state_nx        = state;
        pc_write_d      = 1'b0;
        pc_write_cond_d = 1'b0;
        iord_d          = 1'b0;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        ir_write_d      = 1'b0;
        mem_to_reg_d    = 1'b0;
        reg_dst_d       = 1'b0;
        reg_write_d     = 1'b0;
        alu_src_a_d     = 1'b0;
        alu_src_b_d     = SRCB_B;
        alu_op_d        = ALUOP_ADD;
        pc_source_d     = PCSRC_ALU;
        instr_done_d    = 1'b0;
        illegal_op_d    = 1'b0;
        mem_timeout_d   = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read_d  = 1'b1;
                alu_src_b_d = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write_d = 1'b1;
                    pc_write_d = 1'b1;
                    state_nx   = S_DECODE;
                end else if (at_lim) begin
                    mem_timeout_d = 1'b1;
                    state_nx      = S_FETCH;
                end
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode decodes.
                alu_src_b_d = SRCB_IMM_SH2;
                case (opcode)
                    OP_LW, OP_SW: state_nx = S_MEM_ADR;
                    OP_RTYPE:     state_nx = S_EXECUTE;
                    OP_BEQ:       state_nx = S_BRANCH;
                    OP_J:         state_nx = S_JUMP;
`ifdef MIPS_MC_ADDI_EN
                    OP_ADDI:      state_nx = S_ADDI_EX;
`endif
                    default: begin
                        illegal_op_d = 1'b1;
                        instr_done_d = 1'b1;
                        state_nx     = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = SRCB_IMM;
                // Opcode is still held in IR; only lw/sw reach here.
                state_nx    = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read_d = 1'b1;
                iord_d     = 1'b1;
                if (mem_ready) begin
                    state_nx = S_MEM_WB;
                end else if (at_lim) begin
                    mem_timeout_d = 1'b1;
                    state_nx      = S_FETCH;
                end
            end
            S_MEM_WB: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
                instr_done_d = 1'b1;
                state_nx     = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write_d = 1'b1;
                iord_d      = 1'b1;
                if (mem_ready) begin
                    instr_done_d = 1'b1;
                    state_nx     = S_FETCH;
                end else if (at_lim) begin
                    mem_timeout_d = 1'b1;
                    state_nx      = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_src_a_d = 1'b1;
                alu_op_d    = ALUOP_RTYPE;
                state_nx    = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_d  = 1'b1;
                reg_dst_d    = 1'b1;
                instr_done_d = 1'b1;
                state_nx     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_d     = 1'b1;
                alu_op_d        = ALUOP_SUB;
                pc_write_cond_d = 1'b1;
                pc_source_d     = PCSRC_ALUOUT;
                instr_done_d    = 1'b1;
                state_nx        = S_FETCH;
            end
            S_JUMP: begin
                pc_write_d   = 1'b1;
                pc_source_d  = PCSRC_JUMP;
                instr_done_d = 1'b1;
                state_nx     = S_FETCH;
            end
`ifdef MIPS_MC_ADDI_EN
            S_ADDI_EX: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = SRCB_IMM;
                state_nx    = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write_d  = 1'b1;
                instr_done_d = 1'b1;
                state_nx     = S_FETCH;
            end
`endif
            default: state_nx = S_FETCH;
        endcase
    end

    assign pc_write      = pc_write_d      & ~rst;
    assign pc_write_cond = pc_write_cond_d & ~rst;
    assign iord          = iord_d          & ~rst;
    assign mem_read      = mem_read_d      & ~rst;
    assign mem_write     = mem_write_d     & ~rst;
    assign ir_write      = ir_write_d      & ~rst;
    assign mem_to_reg    = mem_to_reg_d    & ~rst;
    assign reg_dst       = reg_dst_d       & ~rst;
    assign reg_write     = reg_write_d     & ~rst;
    assign alu_src_a     = alu_src_a_d     & ~rst;
    assign alu_src_b     = alu_src_b_d     & {2{~rst}};
    assign alu_op        = alu_op_d        & {3{~rst}};
    assign pc_source     = pc_source_d     & {2{~rst}};
    assign instr_done    = instr_done_d    & ~rst;
    assign illegal_op    = illegal_op_d    & ~rst;
    assign mem_timeout   = mem_timeout_d   & ~rst;

endmodule
